// File: rtl/iter_divider.sv
// ----------------------------------------------------------------------------
// iter_divider
//
// Multi-cycle restoring divider for DIV/DIVU in the EX stage. It takes one
// operand pair per operation and stalls the pipe through busy_o while it
// works. The result is {remainder, quotient}. Writeback routes the upper half
// to HI and the lower half to LO.
//
// Timing: start_i is sampled at edge E while idle. busy_o is high for the
// cycles that follow E: WIDTH CALC cycles plus one FINISH cycle. done_o and
// the new result_o show up together after the edge that ends FINISH, and
// busy_o is low in that done cycle. A new start may be sampled in the done
// cycle.
//
// Ports
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous, active-high reset (priority over flush/start)
//   start_i      request a divide; only looked at while idle
//   is_signed_i  1 = DIV (two's complement), 0 = DIVU
//   dividend_i   rs operand, captured with start_i
//   divisor_i    rt operand, captured with start_i
//   flush_i      abort an in-flight operation; no done is produced
//   busy_o       operation in flight; the pipeline must stall EX
//   done_o       one-cycle pulse; result_o is valid from this cycle
//   result_o     {remainder, quotient}; holds until the next done_o
// ----------------------------------------------------------------------------
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               is_signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Control state (reset)
    logic [1:0]         state_q,  state_d;
    logic [CW-1:0]      count_q,  count_d;
    logic               done_q,   done_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    // Datapath state (not reset)
    logic [WIDTH-1:0]   rem_q,      rem_d;
    logic [WIDTH-1:0]   quo_q,      quo_d;
    logic [WIDTH-1:0]   dvs_q,      dvs_d;
    logic               sign_q_q,   sign_q_d;
    logic               sign_r_q,   sign_r_d;
    logic               dvs_zero_q, dvs_zero_d;

    // Operand conditioning
    logic               dvd_neg, dvs_neg;
    logic [WIDTH-1:0]   dvd_abs, dvs_abs;

    // Iteration datapath
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               load, step;

    assign dvd_neg = is_signed_i & dividend_i[WIDTH-1];
    assign dvs_neg = is_signed_i & divisor_i[WIDTH-1];
    // -2^(WIDTH-1) wraps to itself. Read as an unsigned magnitude, that is
    // the correct value, so the most negative operand needs no special case.
    assign dvd_abs = dvd_neg ? -dividend_i : dividend_i;
    assign dvs_abs = dvs_neg ? -divisor_i  : divisor_i;

    // Shift {rem,quo} left by one. Then try to subtract the divisor on
    // WIDTH+1 bits, where the top bit is the borrow.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    // For a zero divisor the loop gives an all-ones quotient and |dividend|.
    // The quotient keeps that raw value. The remainder still takes the
    // dividend's sign, which gives back exactly the original dividend.
    assign quo_fix = (sign_q_q && !dvs_zero_q) ? -quo_q : quo_q;
    assign rem_fix = sign_r_q ? -rem_q : rem_q;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // flush wins over a simultaneous start
                if (start_i && !flush_i) begin
                    state_d = ST_CALC;
                    count_d = '0;
                    load    = 1'b1;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    step    = 1'b1;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = {rem_fix, quo_fix};
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        sign_q_d   = sign_q_q;
        sign_r_d   = sign_r_q;
        dvs_zero_d = dvs_zero_q;

        if (load) begin
            rem_d      = '0;
            quo_d      = dvd_abs;
            dvs_d      = dvs_abs;
            sign_q_d   = dvd_neg ^ dvs_neg;
            sign_r_d   = dvd_neg;
            dvs_zero_d = (divisor_i == '0);
        end else if (step) begin
            // Keep the trial difference only when it did not borrow.
            rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // NOTE: the datapath registers are not reset. Each one is loaded on start
    // before it is read, and leaving reset off keeps them plain flops.
    always_ff @(posedge clk_i) begin
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        dvs_q      <= dvs_d;
        sign_q_q   <= sign_q_d;
        sign_r_q   <= sign_r_d;
        dvs_zero_q <= dvs_zero_d;
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// ----------------------------------------------------------------------------
// tb_iter_divider
//
// Directed test of iter_divider (WIDTH=32). A table of operand pairs with
// hand-computed {remainder, quotient} values is applied one operation at a
// time. Each operation's result, latency and busy length are compared. After
// that come hand-written sequences for re-start while busy, flush, flush
// against start, reset in mid-operation, and back-to-back operations.
//
// The latency is the number of rising edges from the edge that samples start
// to the edge after which done is visible, counting the sampling edge as 1.
// ----------------------------------------------------------------------------
module tb_iter_divider;

    localparam int W        = 32;
    localparam int LATENCY  = 34;
    localparam int BUSY_LEN = 33;
    localparam int BUDGET   = 80;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           flush;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;

    iter_divider #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .is_signed_i (is_signed),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .flush_i     (flush),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic           sgn;
        logic [W-1:0]   dvd;
        logic [W-1:0]   dvs;
        logic [2*W-1:0] exp;   // {remainder, quotient}
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for the next edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it to done (or until the budget runs
    // out). If repulse_at is non-zero, start is pulsed again with different
    // operands at that observation. The task returns inside the done cycle,
    // so a following call gives back-to-back starts.
    task automatic run_op(input logic sgn, input logic [W-1:0] dvd,
                          input logic [W-1:0] dvs, input int repulse_at,
                          output logic [2*W-1:0] res, output int lat,
                          output int busy_cnt);
        is_signed = sgn;
        dividend  = dvd;
        divisor   = dvs;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        res       = '0;
        for (int obs = 1; obs <= BUDGET; obs++) begin
            if (done) begin
                lat = obs;
                res = result;
                break;
            end
            if (busy) busy_cnt++;
            if (repulse_at != 0 && obs == repulse_at) begin
                is_signed = 1'b0;
                dividend  = 32'd50;
                divisor   = 32'd5;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    logic [2*W-1:0] res, res2;
    int             lat, lat2, bcnt, bcnt2, done_seen;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14}};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1,        32'hFFFF_FFFD}};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'd0,        32'h8000_0000}};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,        {32'd5,        32'hFFFF_FFFF}};
        vecs[5]  = '{1'b0, 32'd3,          32'd10,       {32'd3,        32'd0}};
        vecs[6]  = '{1'b1, 32'hFFFF_FFFD,  32'd10,       {32'hFFFF_FFFD, 32'd0}};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        {32'd0,        32'hFFFF_FFFF}};
        vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,        {32'hFFFF_FFF9, 32'hFFFF_FFFF}};
        vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'd0}};
        vecs[10] = '{1'b1, 32'd100,        32'hFFFF_FFF9, {32'd2,        32'hFFFF_FFF2}};
        vecs[11] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}};
        vecs[12] = '{1'b0, 32'hDEAD_BEEF,  32'd16,       {32'd15,       32'h0DEA_DBEE}};

        rst = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        tick(); tick();
        check("reset_busy",   {63'd0, busy}, 64'd0);
        check("reset_done",   {63'd0, done}, 64'd0);
        check("reset_result", result,        64'd0);
        rst = 1'b0;
        tick();

        // Table-driven operations
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].sgn, vecs[i].dvd, vecs[i].dvs, 0, res, lat, bcnt);
            check($sformatf("vec%0d_result", i),  res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LATENCY));
            check($sformatf("vec%0d_busylen", i), 64'(bcnt), 64'(BUSY_LEN));
            check($sformatf("vec%0d_busy_in_done", i), {63'd0, busy}, 64'd0);
            tick();
        end
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("result_holds",   result, vecs[NV-1].exp);

        // Start again while busy: ignored, original result returned
        run_op(1'b0, 32'd100, 32'd7, 10, res, lat, bcnt);
        check("repulse_result",  res, {32'd2, 32'd14});
        check("repulse_latency", 64'(lat), 64'(LATENCY));
        tick();
        check("repulse_no_restart", {63'd0, busy}, 64'd0);

        // Flush at observation 20 of a fresh operation
        is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int obs = 1; obs < 20; obs++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy_low", {63'd0, busy}, 64'd0);
        check("flush_no_done",  {63'd0, done}, 64'd0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_seen++;
            tick();
        end
        check("flush_never_done",   64'(done_seen), 64'd0);
        check("flush_result_keeps", result, {32'd2, 32'd14});

        // Flush and start together in idle: flush wins
        is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", {63'd0, busy}, 64'd0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_seen++;
            tick();
        end
        check("flush_start_no_done", 64'(done_seen), 64'd0);

        // Reset in the middle of CALC
        is_signed = 1'b0; dividend = 32'd77; divisor = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int obs = 1; obs < 15; obs++) tick();
        check("midcalc_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midcalc_rst_busy",   {63'd0, busy}, 64'd0);
        check("midcalc_rst_done",   {63'd0, done}, 64'd0);
        check("midcalc_rst_result", result,        64'd0);

        // Two back-to-back operations: the second start lands in the done cycle
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, res, lat, bcnt);
        run_op(1'b0, 32'd1000, 32'd3, 0, res2, lat2, bcnt2);
        check("b2b_first_result",   res,  {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("b2b_first_latency",  64'(lat),  64'(LATENCY));
        check("b2b_second_result",  res2, {32'd1, 32'd333});
        check("b2b_second_latency", 64'(lat2), 64'(LATENCY));
        check("b2b_second_busylen", 64'(bcnt2), 64'(BUSY_LEN));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
